// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Pending-write scoreboard for the 32-entry integer register file;
//            produces the decode stall and tracks in-flight writes.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int CNT_W    = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                issue_valid,
   input  logic [ADDR_W-1:0]   issue_rd,
   input  logic                issue_wen,
   input  logic [ADDR_W-1:0]   rs1,
   input  logic [ADDR_W-1:0]   rs2,
   input  logic                rs1_used,
   input  logic                rs2_used,
   input  logic                wb_valid,
   input  logic [ADDR_W-1:0]   wb_rd,
   input  logic                flush,
   output logic                stall,
   output logic                issue_fire,
   output logic [NUM_REGS-1:0] busy_mask,
   output logic [6:0]          outstanding,
   output logic                underflow_err
);

   localparam logic [CNT_W-1:0]  C_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  C_CNT_ONE = CNT_W'(1);
   localparam logic [ADDR_W-1:0] C_X0      = '0;

   logic [CNT_W-1:0]    cnt_q [NUM_REGS];
   logic [CNT_W-1:0]    cnt_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy_mask_q, busy_mask_d;
   logic [6:0]          outstanding_q, outstanding_d;
   logic                underflow_q, underflow_d;

   logic w_rs1_haz, w_rs2_haz, w_sat_haz, w_stall, w_fire;
   logic w_inc, w_dec, w_underflow, w_inc_hit, w_dec_hit;

   // A final writeback this cycle clears the hazard: the file writes on
   // posedge and decode reads it on the following negedge.
   always_comb begin
      w_rs1_haz = rs1_used && (rs1 != C_X0) && (cnt_q[rs1] != '0) &&
                  !(wb_valid && (wb_rd == rs1) && (cnt_q[rs1] == C_CNT_ONE));
      w_rs2_haz = rs2_used && (rs2 != C_X0) && (cnt_q[rs2] != '0) &&
                  !(wb_valid && (wb_rd == rs2) && (cnt_q[rs2] == C_CNT_ONE));
      w_sat_haz = issue_wen && (issue_rd != C_X0) && (cnt_q[issue_rd] == C_CNT_MAX) &&
                  !(wb_valid && (wb_rd == issue_rd));
      w_stall   = issue_valid && (w_rs1_haz || w_rs2_haz || w_sat_haz) && !flush;
      w_fire    = issue_valid && !w_stall;
      w_inc     = w_fire && issue_wen && (issue_rd != C_X0) && !flush;
      w_dec     = wb_valid && (wb_rd != C_X0) && !flush;
   end

   always_comb begin
      w_underflow = 1'b0;
      w_inc_hit   = 1'b0;
      w_dec_hit   = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt_d[i] = cnt_q[i];
      end
      cnt_d[0] = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         w_inc_hit = w_inc && (issue_rd == ADDR_W'(i));
         w_dec_hit = w_dec && (wb_rd == ADDR_W'(i));
         if (w_inc_hit && !w_dec_hit) begin
            cnt_d[i] = cnt_q[i] + C_CNT_ONE;
         end else if (w_dec_hit && !w_inc_hit) begin
            if (cnt_q[i] == '0) begin
               w_underflow = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] - C_CNT_ONE;
            end
         end
         if (flush) begin
            cnt_d[i] = '0;
         end
      end
   end

   always_comb begin
      busy_mask_d = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         busy_mask_d[i] = (cnt_d[i] != '0);
      end
      if (flush) begin
         outstanding_d = '0;
      end else begin
         outstanding_d = outstanding_q + 7'(w_inc) - 7'(w_dec && !w_underflow);
      end
      underflow_d = underflow_q || w_underflow;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt_q[i] <= '0;
         end
         busy_mask_q   <= '0;
         outstanding_q <= '0;
         underflow_q   <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         busy_mask_q   <= busy_mask_d;
         outstanding_q <= outstanding_d;
         underflow_q   <= underflow_d;
      end
   end

   assign stall         = w_stall;
   assign issue_fire    = w_fire;
   assign busy_mask     = busy_mask_q;
   assign outstanding   = outstanding_q;
   assign underflow_err = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Purpose  : Directed self-checking bench for regfile_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

   logic        clock = 1'b0;
   logic        reset;
   logic        issue_valid, issue_wen, rs1_used, rs2_used, wb_valid, flush;
   logic [4:0]  issue_rd, rs1, rs2, wb_rd;
   logic        stall, issue_fire, underflow_err;
   logic [31:0] busy_mask;
   logic [6:0]  outstanding;

   int n_cmp = 0;
   int n_err = 0;

   regfile_scoreboard dut (
      .clock         (clock),
      .reset         (reset),
      .issue_valid   (issue_valid),
      .issue_rd      (issue_rd),
      .issue_wen     (issue_wen),
      .rs1           (rs1),
      .rs2           (rs2),
      .rs1_used      (rs1_used),
      .rs2_used      (rs2_used),
      .wb_valid      (wb_valid),
      .wb_rd         (wb_rd),
      .flush         (flush),
      .stall         (stall),
      .issue_fire    (issue_fire),
      .busy_mask     (busy_mask),
      .outstanding   (outstanding),
      .underflow_err (underflow_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      issue_valid = 1'b0; issue_wen = 1'b0; issue_rd = 5'd0;
      rs1 = 5'd0; rs2 = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
      wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0;
   endtask

   // Inputs change on negedge; registered outputs are sampled on the next negedge.
   task automatic cyc();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic issue(input logic [4:0] rd);
      idle();
      issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = rd;
      cyc();
   endtask

   task automatic wb(input logic [4:0] rd);
      idle();
      wb_valid = 1'b1; wb_rd = rd;
      cyc();
   endtask

   initial begin
      idle();
      reset = 1'b0;
      @(negedge clock);
      cyc();
      cyc();
      reset = 1'b1;
      #1;
      chk("rst_busy",  busy_mask, 32'h0);
      chk("rst_outst", 32'(outstanding), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_uflow", 32'(underflow_err), 32'd0);
      @(negedge clock);

      // RAW on x5, resolved by same-cycle final writeback
      issue(5'd5);
      idle();
      issue_valid = 1'b1; rs1 = 5'd5; rs1_used = 1'b1;
      #1;
      chk("raw_busy",  busy_mask, 32'h20);
      chk("raw_outst", 32'(outstanding), 32'd1);
      chk("raw_stall", 32'(stall), 32'd1);
      chk("raw_fire",  32'(issue_fire), 32'd0);
      issue_valid = 1'b0;
      #1;
      chk("noval_stall", 32'(stall), 32'd0);
      issue_valid = 1'b1; wb_valid = 1'b1; wb_rd = 5'd5;
      #1;
      chk("bypass_stall", 32'(stall), 32'd0);
      chk("bypass_fire",  32'(issue_fire), 32'd1);
      cyc();
      chk("raw_clr_busy",  busy_mask, 32'h0);
      chk("raw_clr_outst", 32'(outstanding), 32'd0);

      // Saturation on x7
      issue(5'd7); issue(5'd7); issue(5'd7);
      chk("sat_outst", 32'(outstanding), 32'd3);
      chk("sat_busy",  busy_mask, 32'h80);
      idle();
      issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 5'd7;
      #1;
      chk("sat_stall", 32'(stall), 32'd1);
      wb_valid = 1'b1; wb_rd = 5'd7;
      #1;
      chk("sat_wb_stall", 32'(stall), 32'd0);
      chk("sat_wb_fire",  32'(issue_fire), 32'd1);
      cyc();
      chk("sat_hold_outst", 32'(outstanding), 32'd3);
      chk("sat_hold_busy",  busy_mask, 32'h80);
      wb(5'd7); wb(5'd7); wb(5'd7);
      chk("sat_drain_outst", 32'(outstanding), 32'd0);
      chk("sat_drain_busy",  busy_mask, 32'h0);

      // Non-final writeback does not resolve an rs2 hazard
      issue(5'd6); issue(5'd6);
      idle();
      issue_valid = 1'b1; rs2 = 5'd6; rs2_used = 1'b1; wb_valid = 1'b1; wb_rd = 5'd6;
      #1;
      chk("rs2_cnt2_stall", 32'(stall), 32'd1);
      cyc();
      chk("rs2_outst1", 32'(outstanding), 32'd1);
      #1;
      chk("rs2_cnt1_stall", 32'(stall), 32'd0);
      cyc();
      chk("rs2_outst0", 32'(outstanding), 32'd0);

      // x0 is never tracked
      idle();
      issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 5'd0; rs1 = 5'd0; rs1_used = 1'b1;
      #1;
      chk("x0_stall", 32'(stall), 32'd0);
      cyc();
      chk("x0_busy",  busy_mask, 32'h0);
      chk("x0_outst", 32'(outstanding), 32'd0);

      // Flush with simultaneous issue and writeback
      issue(5'd3); issue(5'd4); issue(5'd9);
      chk("pre_flush_busy",  busy_mask, 32'h218);
      chk("pre_flush_outst", 32'(outstanding), 32'd3);
      idle();
      flush = 1'b1; issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 5'd10;
      wb_valid = 1'b1; wb_rd = 5'd3;
      cyc();
      chk("flush_busy",  busy_mask, 32'h0);
      chk("flush_outst", 32'(outstanding), 32'd0);
      chk("flush_uflow", 32'(underflow_err), 32'd0);

      // Underflow is sticky across flush, cleared only by reset
      wb(5'd12);
      chk("uflow_set",   32'(underflow_err), 32'd1);
      chk("uflow_outst", 32'(outstanding), 32'd0);
      idle();
      flush = 1'b1;
      cyc();
      chk("uflow_flush", 32'(underflow_err), 32'd1);
      idle();
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      chk("uflow_reset", 32'(underflow_err), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
